pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter unit for the pipelined CPU's IF stage; next generation of the basic start-gated PC register.
- Adds configurable width, reset/trap vectors and increment step.
- Adds prioritised redirects: exception over branch over sequential.
- Adds true stall hold (no PC rewind), a one-entry pending-redirect buffer for branches resolved during a stall, and a run-control FSM.

Parameters:
- XLEN, 32, PC width in bits.
- RESET_VEC, 32'h0000_0000, PC value after reset (XLEN bits).
- TRAP_VEC, 32'h0000_0080, PC loaded on exception (XLEN bits).
- STEP, 4, sequential increment in bytes; power of two, at least 1.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  run enable from testbench/top
- halt_i  in  1  halt request (one-cycle pulse or level)
- stall_i  in  1  hazard-unit stall: hold PC
- br_valid_i  in  1  branch/jump taken, resolved this cycle
- br_target_i  in  XLEN  branch/jump target
- exc_valid_i  in  1  exception/flush request
- pc_o  out  XLEN  current fetch PC
- fetch_valid_o  out  1  pc_o is a valid fetch address
- redir_pend_o  out  1  pending-redirect buffer occupied
- state_o  out  2  FSM state: 0 IDLE, 1 RUN, 2 HALT
- misalign_o  out  1  misaligned-target flag (optional feature)

Behaviour:
- Reset (rst_i=1, asynchronous, takes effect immediately): pc_o=RESET_VEC, state IDLE, fetch_valid_o=0, redir_pend_o=0, pending target=0, misalign_o=0.
- All outputs are registered; every update below takes effect on the next rising clock edge.
- fetch_valid_o=1 exactly when state is RUN.
- IDLE:
  - pc_o holds.
  - start_i=1 -> RUN; pc_o is unchanged on that edge, so the first fetch is at the held PC.
  - Redirect inputs are ignored.
- RUN, per edge, first matching rule wins:
  1. halt_i=1 -> HALT; pc_o holds; pending cleared.
  2. exc_valid_i=1 -> pc_o=TRAP_VEC; pending cleared. Stall is ignored (flush).
  3. start_i=0 -> IDLE; pc_o holds; pending kept.
  4. stall_i=1 -> pc_o holds. If br_valid_i=1, capture br_target_i into pending and set redir_pend_o. A newer branch in a later stalled cycle overwrites the pending target.
  5. Pending valid -> pc_o=pending target; pending cleared. A concurrent br_valid_i is dropped (wrong path).
  6. br_valid_i=1 -> pc_o=br_target_i.
  7. Otherwise pc_o=pc_o+STEP, modulo 2^XLEN; PC wraps from max to 0 with no flag.
- HALT:
  - pc_o frozen; all inputs ignored.
  - Exit only through rst_i.
- Reset asserted mid-stall or with a pending redirect: everything returns to its reset values; the pending redirect is lost.
- Stall semantics: the PC holds its value, never pc-STEP.
- No combinational path from any input to any output.

Optional Feature:
- Macro: PC_MISALIGN_CHK_EN.
- With the macro defined:
  - A redirect target (direct or pending) whose low log2(STEP) bits are nonzero is not loaded; pc_o=TRAP_VEC instead.
  - misalign_o pulses high for exactly one cycle, on the same edge.
  - The check happens when the target is applied, not when it is captured.
- Without the macro: targets load unmodified and misalign_o is tied to 0.

Decomposition:
- Shared package pc_pkg:
  - FSM state encoding: PC_IDLE=2'd0, PC_RUN=2'd1, PC_HALT=2'd2.
  - Default vector constants.
  - Function computing the alignment mask from STEP.
- One natural sub-module: pc_redirect_buf, the one-entry pending-target register with valid, capture, overwrite and clear.

Test Plan:
- Reset/start: rst_i pulse, then start_i=1 -> state_o=1, fetch_valid_o=1 next edge. pc_o sequence 0x0, 0x0, 0x4, 0x8.
- Stall hold: stall_i=1 for 3 cycles at pc_o=0x10 -> pc_o stays 0x10, never 0x0C. After release the next value is 0x14.
- Branch during stall: at pc_o=0x20, stall_i=1 with br_valid_i=1 and target 0x100 -> redir_pend_o=1 and pc_o holds 0x20. On release pc_o=0x100 and redir_pend_o=0.
- Priority: exc_valid_i, br_valid_i (0x200) and stall_i all 1 in one cycle -> pc_o=0x80 and pending cleared. Simultaneous halt_i=1 instead -> state_o=2 and pc_o holds.
- Wrap and halt: pc_o=0xFFFF_FFFC, run one cycle -> pc_o=0x0. Then halt_i=1 -> pc_o frozen for 5 cycles despite branches; rst_i restores RESET_VEC.
- With PC_MISALIGN_CHK_EN: branch to 0x102 -> pc_o=0x80 and misalign_o high for 1 cycle. Branch to 0x104 -> pc_o=0x104 and misalign_o=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: run-control state encoding,
// default vectors and the alignment-mask helper.
package pc_pkg;

  localparam logic [1:0] PC_IDLE = 2'd0;
  localparam logic [1:0] PC_RUN  = 2'd1;
  localparam logic [1:0] PC_HALT = 2'd2;

  localparam logic [31:0] PC_RESET_VEC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_TRAP_VEC_DEFAULT  = 32'h0000_0080;

  // STEP is a power of two, so the bits below it are simply STEP-1.
  function automatic int unsigned align_mask(input int unsigned step);
    return step - 1;
  endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry pending-redirect register: holds a branch target resolved while
// fetch is stalled until the PC is allowed to move.
module pc_redirect_buf #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_capture,
  input  logic         i_clear,
  input  logic [W-1:0] i_target,
  output logic         o_valid,
  output logic [W-1:0] o_target
);

  logic         r_valid;
  logic [W-1:0] r_target;

  // A later capture simply overwrites the older target.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid  <= 1'b0;
      r_target <= '0;
    end else if (i_capture) begin
      r_valid  <= 1'b1;
      r_target <= i_target;
    end else if (i_clear) begin
      r_valid  <= 1'b0;
    end
  end

  assign o_valid  = r_valid;
  assign o_target = r_target;

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit for the IF stage with prioritised redirects, stall hold,
// pending-redirect buffer and run-control FSM. Optional: PC_MISALIGN_CHK_EN.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_VEC = PC_RESET_VEC_DEFAULT,
  parameter logic [XLEN-1:0]  TRAP_VEC  = PC_TRAP_VEC_DEFAULT,
  parameter int unsigned      STEP      = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            halt_i,
  input  logic            stall_i,
  input  logic            br_valid_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            exc_valid_i,
  output logic [XLEN-1:0] pc_o,
  output logic            fetch_valid_o,
  output logic            redir_pend_o,
  output logic [1:0]      state_o,
  output logic            misalign_o
);

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_misalign;

  logic [1:0]      w_state_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic            w_misalign_nxt;
  logic            w_capture;
  logic            w_clear;
  logic            w_pend_valid;
  logic [XLEN-1:0] w_pend_target;
  logic [XLEN-1:0] w_tgt;
  logic            w_tgt_bad;

  pc_redirect_buf #(.W(XLEN)) u_redirect_buf (
    .i_clk    (clk_i),
    .i_rst    (rst_i),
    .i_capture(w_capture),
    .i_clear  (w_clear),
    .i_target (br_target_i),
    .o_valid  (w_pend_valid),
    .o_target (w_pend_target)
  );

  // A pending target always wins over a fresh branch (the fresh one is wrong-path).
  assign w_tgt = w_pend_valid ? w_pend_target : br_target_i;

`ifdef PC_MISALIGN_CHK_EN
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(align_mask(STEP));
  assign w_tgt_bad = |(w_tgt & ALIGN_MASK);
`else
  assign w_tgt_bad = 1'b0;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_misalign_nxt = 1'b0;
    w_capture      = 1'b0;
    w_clear        = 1'b0;
    case (r_state)
      PC_IDLE: begin
        if (start_i) w_state_nxt = PC_RUN;
      end
      PC_RUN: begin
        if (halt_i) begin
          w_state_nxt = PC_HALT;
          w_clear     = 1'b1;
        end else if (exc_valid_i) begin
          w_pc_nxt = TRAP_VEC;
          w_clear  = 1'b1;
        end else if (!start_i) begin
          w_state_nxt = PC_IDLE;
        end else if (stall_i) begin
          w_capture = br_valid_i;
        end else if (w_pend_valid || br_valid_i) begin
          w_clear = w_pend_valid;
          if (w_tgt_bad) begin
            w_pc_nxt       = TRAP_VEC;
            w_misalign_nxt = 1'b1;
          end else begin
            w_pc_nxt = w_tgt;
          end
        end else begin
          w_pc_nxt = r_pc + XLEN'(STEP);
        end
      end
      PC_HALT: begin
      end
      default: w_state_nxt = PC_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= PC_IDLE;
      r_pc       <= RESET_VEC;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end

  assign pc_o          = r_pc;
  assign state_o       = r_state;
  assign fetch_valid_o = (r_state == PC_RUN);
  assign redir_pend_o  = w_pend_valid;
  assign misalign_o    = r_misalign;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit; covers reset/start, stall hold,
// pending redirects, priorities, wrap, halt and the misalignment check.
module tb_pc_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        halt_i;
  logic        stall_i;
  logic        br_valid_i;
  logic [31:0] br_target_i;
  logic        exc_valid_i;
  logic [31:0] pc_o;
  logic        fetch_valid_o;
  logic        redir_pend_o;
  logic [1:0]  state_o;
  logic        misalign_o;

  int n_checks = 0;
  int n_fail   = 0;

  pc_unit dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .halt_i       (halt_i),
    .stall_i      (stall_i),
    .br_valid_i   (br_valid_i),
    .br_target_i  (br_target_i),
    .exc_valid_i  (exc_valid_i),
    .pc_o         (pc_o),
    .fetch_valid_o(fetch_valid_o),
    .redir_pend_o (redir_pend_o),
    .state_o      (state_o),
    .misalign_o   (misalign_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    halt_i      = 1'b0;
    stall_i     = 1'b0;
    br_valid_i  = 1'b0;
    br_target_i = 32'h0;
    exc_valid_i = 1'b0;
  endtask

  task automatic check_pc(input string name, input logic [31:0] exp);
    n_checks++;
    if (pc_o !== exp) begin
      n_fail++;
      $display("FAIL %s: pc_o got %h expected %h", name, pc_o, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check_state(input string name, input logic [1:0] exp);
    n_checks++;
    if (state_o !== exp) begin
      n_fail++;
      $display("FAIL %s: state_o got %0d expected %0d", name, state_o, exp);
    end
  endtask

  task automatic do_reset();
    rst_i   = 1'b1;
    start_i = 1'b0;
    clear_inputs();
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i   = 1'b1;
    start_i = 1'b0;
    clear_inputs();
    #1;
    check_pc("reset_pc", 32'h0);
    check_state("reset_state", 2'd0);
    check_bit("reset_fetch_valid", fetch_valid_o, 1'b0);
    check_bit("reset_pend", redir_pend_o, 1'b0);
    check_bit("reset_misalign", misalign_o, 1'b0);
    step();
    rst_i = 1'b0;
    step();
    check_pc("idle_hold_pc", 32'h0);
    check_state("idle_hold_state", 2'd0);
  endtask

  task automatic test_start();
    start_i = 1'b1;
    step();
    check_state("start_state", 2'd1);
    check_bit("start_fetch_valid", fetch_valid_o, 1'b1);
    check_pc("start_first_pc", 32'h0);
    step();
    check_pc("seq_pc_4", 32'h4);
    step();
    check_pc("seq_pc_8", 32'h8);
  endtask

  task automatic test_stall_hold();
    step();
    step();
    check_pc("pre_stall_pc", 32'h10);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_pc("stall_hold_pc", 32'h10);
    end
    stall_i = 1'b0;
    step();
    check_pc("stall_release_pc", 32'h14);
  endtask

  task automatic test_branch_during_stall();
    br_valid_i = 1'b1; br_target_i = 32'h20;
    step();
    check_pc("direct_branch_pc", 32'h20);
    stall_i = 1'b1; br_target_i = 32'h100;
    step();
    check_pc("stall_br_hold_pc", 32'h20);
    check_bit("stall_br_pend", redir_pend_o, 1'b1);
    br_target_i = 32'h180;
    step();
    check_pc("stall_br2_hold_pc", 32'h20);
    check_bit("stall_br2_pend", redir_pend_o, 1'b1);
    // Release with a fresh branch present: the pending (overwritten) target wins.
    stall_i = 1'b0; br_target_i = 32'h300;
    step();
    check_pc("pend_apply_pc", 32'h180);
    check_bit("pend_apply_clear", redir_pend_o, 1'b0);
    br_valid_i = 1'b0;
    step();
    check_pc("after_pend_seq_pc", 32'h184);
  endtask

  task automatic test_priority();
    stall_i = 1'b1; br_valid_i = 1'b1; br_target_i = 32'h240;
    step();
    check_bit("prio_pend_set", redir_pend_o, 1'b1);
    exc_valid_i = 1'b1; br_target_i = 32'h200;
    step();
    check_pc("prio_exc_pc", 32'h80);
    check_bit("prio_exc_pend_clear", redir_pend_o, 1'b0);
    clear_inputs();
    step();
    check_pc("post_exc_seq_pc", 32'h84);
    halt_i = 1'b1; exc_valid_i = 1'b1; stall_i = 1'b1;
    br_valid_i = 1'b1; br_target_i = 32'h200;
    step();
    check_state("prio_halt_state", 2'd2);
    check_pc("prio_halt_pc", 32'h84);
    check_bit("prio_halt_fetch_valid", fetch_valid_o, 1'b0);
    clear_inputs();
    rst_i = 1'b1;
    #1;
    check_pc("async_reset_pc", 32'h0);
    check_state("async_reset_state", 2'd0);
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_idle_keeps_pending();
    start_i = 1'b1;
    step();
    step();
    check_pc("idle_pre_pc", 32'h4);
    stall_i = 1'b1; br_valid_i = 1'b1; br_target_i = 32'h400;
    step();
    check_bit("idle_pend_set", redir_pend_o, 1'b1);
    start_i = 1'b0; clear_inputs();
    step();
    check_state("run_to_idle_state", 2'd0);
    check_pc("run_to_idle_pc", 32'h4);
    check_bit("idle_pend_kept", redir_pend_o, 1'b1);
    br_valid_i = 1'b1; br_target_i = 32'h500; exc_valid_i = 1'b1;
    step();
    check_pc("idle_ignores_redirect", 32'h4);
    clear_inputs(); start_i = 1'b1;
    step();
    check_pc("restart_pc", 32'h4);
    step();
    check_pc("restart_pend_pc", 32'h400);
    check_bit("restart_pend_clear", redir_pend_o, 1'b0);
  endtask

  task automatic test_wrap_halt();
    br_valid_i = 1'b1; br_target_i = 32'hFFFF_FFFC;
    step();
    check_pc("wrap_pre_pc", 32'hFFFF_FFFC);
    br_valid_i = 1'b0;
    step();
    check_pc("wrap_pc", 32'h0);
    halt_i = 1'b1;
    step();
    check_state("halt_state", 2'd2);
    halt_i = 1'b0; br_valid_i = 1'b1; br_target_i = 32'h700;
    for (int i = 0; i < 5; i++) begin
      start_i = i[0];
      exc_valid_i = i[1];
      step();
      check_pc("halt_frozen_pc", 32'h0);
      check_state("halt_frozen_state", 2'd2);
    end
    start_i = 1'b0;
    do_reset();
    check_pc("halt_reset_pc", 32'h0);
    check_state("halt_reset_state", 2'd0);
  endtask

  task automatic test_reset_with_pending();
    start_i = 1'b1;
    step();
    step();
    stall_i = 1'b1; br_valid_i = 1'b1; br_target_i = 32'h600;
    step();
    check_bit("rst_pend_set", redir_pend_o, 1'b1);
    rst_i = 1'b1;
    #1;
    check_bit("rst_pend_lost", redir_pend_o, 1'b0);
    check_pc("rst_pend_pc", 32'h0);
    clear_inputs();
    step();
    rst_i = 1'b0;
    step();
    check_pc("rst_restart_pc", 32'h0);
    step();
    check_pc("rst_no_stale_redirect", 32'h4);
  endtask

  task automatic test_misalign();
    br_valid_i = 1'b1; br_target_i = 32'h102;
    step();
`ifdef PC_MISALIGN_CHK_EN
    check_pc("misalign_direct_pc", 32'h80);
    check_bit("misalign_direct_flag", misalign_o, 1'b1);
`else
    check_pc("misalign_direct_pc", 32'h102);
    check_bit("misalign_direct_flag", misalign_o, 1'b0);
`endif
    br_target_i = 32'h104;
    step();
    check_pc("aligned_branch_pc", 32'h104);
    check_bit("aligned_branch_flag", misalign_o, 1'b0);
    stall_i = 1'b1; br_target_i = 32'h0A;
    step();
    check_bit("misalign_capture_no_flag", misalign_o, 1'b0);
    stall_i = 1'b0; br_valid_i = 1'b0;
    step();
`ifdef PC_MISALIGN_CHK_EN
    check_pc("misalign_pend_pc", 32'h80);
    check_bit("misalign_pend_flag", misalign_o, 1'b1);
`else
    check_pc("misalign_pend_pc", 32'h0A);
    check_bit("misalign_pend_flag", misalign_o, 1'b0);
`endif
    step();
    check_bit("misalign_flag_drops", misalign_o, 1'b0);
  endtask

  initial begin
    test_reset();
    test_start();
    test_stall_hold();
    test_branch_during_stall();
    test_priority();
    test_idle_keeps_pending();
    test_wrap_halt();
    test_reset_with_pending();
    test_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
